// File: rtl/uninasoc_pkg.sv
// Shared AXI encodings and engine state types for the SoC memory-mapped slaves.
package uninasoc_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  function automatic logic [1:0] axi_resp_merge(input logic i_dec, input logic i_slv);
    return i_dec ? AXI_RESP_DECERR : (i_slv ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI beat address stepping, burst legality and memory range decode.
module axi_burst_addr_gen
  import uninasoc_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           DEPTH      = 1024
) (
  input  logic [ADDR_WIDTH-1:0]    i_addr,
  input  logic [7:0]               i_len,
  input  logic [2:0]               i_size,
  input  logic [1:0]               i_burst,
  output logic [ADDR_WIDTH-1:0]    o_next_addr,
  output logic                     o_illegal,
  output logic                     o_in_range,
  output logic [$clog2(DEPTH)-1:0] o_word
);

  localparam int unsigned         IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] SPAN  = (ADDR_WIDTH+1)'(4 * DEPTH);

  logic [ADDR_WIDTH-1:0] w_bytes;
  logic [ADDR_WIDTH-1:0] w_total;
  logic [ADDR_WIDTH-1:0] w_bound;
  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_wrap_len_ok;
  logic                  w_unused_ok;

  assign w_bytes = ADDR_WIDTH'(1) << i_size;
  assign w_total = w_bytes * (ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1));
  assign w_bound = i_addr & ~(w_total - ADDR_WIDTH'(1));

  always_comb begin
    w_wrap_len_ok = 1'b0;
    case (i_len)
      8'd1, 8'd3, 8'd7, 8'd15: w_wrap_len_ok = 1'b1;
      default:                 w_wrap_len_ok = 1'b0;
    endcase
  end

  always_comb begin
    o_next_addr = i_addr;
    case (i_burst)
      AXI_BURST_INCR: o_next_addr = (i_addr & ~(w_bytes - ADDR_WIDTH'(1))) + w_bytes;
      AXI_BURST_WRAP: o_next_addr = w_bound +
                                    ((i_addr + w_bytes - w_bound) & (w_total - ADDR_WIDTH'(1)));
      default:        o_next_addr = i_addr;
    endcase
  end

  assign o_illegal = (i_burst == 2'b11) || (i_size > 3'd2) ||
                     ((i_burst == AXI_BURST_WRAP) && !w_wrap_len_ok);

  // Addresses below BASE_ADDR wrap to large offsets and fall out of range.
  assign w_off      = i_addr - BASE_ADDR;
  assign o_in_range = {1'b0, w_off} < SPAN;
  assign o_word     = w_off[IDX_W+1:2];

  assign w_unused_ok = ^{w_off[ADDR_WIDTH-1:IDX_W+2], w_off[1:0]};

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave terminating bursts into an internal word memory; independent
// single-outstanding read and write engines.
module axi_mem_responder
  import uninasoc_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           ID_WIDTH   = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           DEPTH      = 1024
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic [ID_WIDTH-1:0]       s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awlock,
  input  logic [3:0]                s_axi_awcache,
  input  logic [2:0]                s_axi_awprot,
  input  logic [3:0]                s_axi_awqos,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ID_WIDTH-1:0]       s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arlock,
  input  logic [3:0]                s_axi_arcache,
  input  logic [2:0]                s_axi_arprot,
  input  logic [3:0]                s_axi_arqos,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [ID_WIDTH-1:0]       s_axi_rid,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // ---------------- write engine ----------------
  wr_state_t             r_wstate, w_wnext;
  logic [ID_WIDTH-1:0]   r_bid;
  logic [1:0]            r_bresp;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_wlen, r_wcnt;
  logic [2:0]            r_wsize;
  logic [1:0]            r_wburst;
  logic                  r_wlast_err, r_wdec;
  logic                  w_wbeat, w_wfinal, w_wlast_bad, w_wen;
  logic [ADDR_WIDTH-1:0] w_wnext_addr;
  logic                  w_willegal, w_win_range;
  logic [IDX_W-1:0]      w_widx;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .DEPTH      (DEPTH)
  ) u_wr_gen (
    .i_addr      (r_waddr),
    .i_len       (r_wlen),
    .i_size      (r_wsize),
    .i_burst     (r_wburst),
    .o_next_addr (w_wnext_addr),
    .o_illegal   (w_willegal),
    .o_in_range  (w_win_range),
    .o_word      (w_widx)
  );

  assign w_wfinal    = (r_wcnt == r_wlen);
  assign w_wlast_bad = w_wbeat && (s_axi_wlast != w_wfinal);
  assign w_wen       = w_wbeat && w_win_range && !w_willegal;

  // Ready/valid are gated by reset so they read 0 while reset is held.
  always_comb begin
    w_wnext       = r_wstate;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    w_wbeat       = 1'b0;
    if (!reset_i) begin
      case (r_wstate)
        W_IDLE: begin
          s_axi_awready = 1'b1;
          if (s_axi_awvalid) w_wnext = W_DATA;
        end
        W_DATA: begin
          s_axi_wready = 1'b1;
          if (s_axi_wvalid) begin
            w_wbeat = 1'b1;
            if (w_wfinal) w_wnext = W_RESP;
          end
        end
        W_RESP: begin
          s_axi_bvalid = 1'b1;
          if (s_axi_bready) w_wnext = W_IDLE;
        end
        default: w_wnext = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_wstate    <= W_IDLE;
      r_bid       <= '0;
      r_bresp     <= '0;
      r_waddr     <= '0;
      r_wlen      <= '0;
      r_wcnt      <= '0;
      r_wsize     <= '0;
      r_wburst    <= '0;
      r_wlast_err <= 1'b0;
      r_wdec      <= 1'b0;
    end else begin
      r_wstate <= w_wnext;
      if (s_axi_awready && s_axi_awvalid) begin
        r_bid       <= s_axi_awid;
        r_waddr     <= s_axi_awaddr;
        r_wlen      <= s_axi_awlen;
        r_wsize     <= s_axi_awsize;
        r_wburst    <= s_axi_awburst;
        r_wcnt      <= '0;
        r_wlast_err <= 1'b0;
        r_wdec      <= 1'b0;
      end
      if (w_wbeat) begin
        r_waddr     <= w_wnext_addr;
        r_wcnt      <= r_wcnt + 8'd1;
        r_wlast_err <= r_wlast_err | w_wlast_bad;
        r_wdec      <= r_wdec | !w_win_range;
        if (w_wfinal)
          r_bresp <= axi_resp_merge(r_wdec | !w_win_range,
                                    r_wlast_err | w_wlast_bad | w_willegal);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (w_wen) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) r_mem[w_widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  assign s_axi_bid   = r_bid;
  assign s_axi_bresp = r_bresp;

  // ---------------- read engine ----------------
  rd_state_t             r_rstate, w_rnext;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rlast;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]            r_rlen, r_rcnt, w_rcnt_next;
  logic [2:0]            r_rsize;
  logic [1:0]            r_rburst;
  logic                  w_rload, w_ridle;
  logic [ADDR_WIDTH-1:0] w_raddr_sel, w_rnext_addr;
  logic [7:0]            w_rlen_sel;
  logic [2:0]            w_rsize_sel;
  logic [1:0]            w_rburst_sel;
  logic                  w_rillegal, w_rin_range;
  logic [IDX_W-1:0]      w_ridx;

  // In idle the generator sees the AR channel directly so the first beat can
  // be fetched on the handshake edge; afterwards it steps the latched address.
  assign w_ridle      = (r_rstate == R_IDLE);
  assign w_raddr_sel  = w_ridle ? s_axi_araddr  : r_raddr;
  assign w_rlen_sel   = w_ridle ? s_axi_arlen   : r_rlen;
  assign w_rsize_sel  = w_ridle ? s_axi_arsize  : r_rsize;
  assign w_rburst_sel = w_ridle ? s_axi_arburst : r_rburst;
  assign w_rcnt_next  = w_ridle ? 8'd0 : r_rcnt + 8'd1;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .DEPTH      (DEPTH)
  ) u_rd_gen (
    .i_addr      (w_raddr_sel),
    .i_len       (w_rlen_sel),
    .i_size      (w_rsize_sel),
    .i_burst     (w_rburst_sel),
    .o_next_addr (w_rnext_addr),
    .o_illegal   (w_rillegal),
    .o_in_range  (w_rin_range),
    .o_word      (w_ridx)
  );

  always_comb begin
    w_rnext       = r_rstate;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    w_rload       = 1'b0;
    if (!reset_i) begin
      case (r_rstate)
        R_IDLE: begin
          s_axi_arready = 1'b1;
          if (s_axi_arvalid) begin
            w_rnext = R_DATA;
            w_rload = 1'b1;
          end
        end
        R_DATA: begin
          s_axi_rvalid = 1'b1;
          if (s_axi_rready) begin
            if (r_rlast) w_rnext = R_IDLE;
            else         w_rload = 1'b1;
          end
        end
        default: w_rnext = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_rstate <= R_IDLE;
      r_rid    <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
      r_rlast  <= 1'b0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
    end else begin
      r_rstate <= w_rnext;
      if (s_axi_arready && s_axi_arvalid) begin
        r_rid    <= s_axi_arid;
        r_rlen   <= s_axi_arlen;
        r_rsize  <= s_axi_arsize;
        r_rburst <= s_axi_arburst;
      end
      if (w_rload) begin
        r_rdata <= (w_rillegal || !w_rin_range) ? '0 : r_mem[w_ridx];
        r_rresp <= axi_resp_merge(!w_rin_range, w_rillegal);
        r_rlast <= (w_rcnt_next == w_rlen_sel);
        r_rcnt  <= w_rcnt_next;
        r_raddr <= w_rnext_addr;
      end
    end
  end

  assign s_axi_rid   = r_rid;
  assign s_axi_rdata = r_rdata;
  assign s_axi_rresp = r_rresp;
  assign s_axi_rlast = r_rlast;

  logic w_unused_ok;
  assign w_unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed and randomized bursts against a byte-level memory model of the responder.
module tb_axi_mem_responder;

  localparam int          DEPTH = 1024;
  localparam int          ID_W  = 2;
  localparam logic [31:0] BASE  = 32'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [ID_W-1:0] awid, arid, bid, rid;
  logic [31:0]     awaddr, araddr, wdata, rdata;
  logic [7:0]      awlen, arlen;
  logic [2:0]      awsize, arsize;
  logic [1:0]      awburst, arburst, bresp, rresp;
  logic [3:0]      wstrb;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic            lock_z  = 1'b0;
  logic [3:0]      cache_z = 4'h0;
  logic [2:0]      prot_z  = 3'h0;
  logic [3:0]      qos_z   = 4'h0;

  axi_mem_responder #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .ID_WIDTH   (ID_W),
    .BASE_ADDR  (BASE),
    .DEPTH      (DEPTH)
  ) dut (
    .clock_i(clk), .reset_i(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(lock_z), .s_axi_awcache(cache_z),
    .s_axi_awprot(prot_z), .s_axi_awqos(qos_z), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(lock_z), .s_axi_arcache(cache_z),
    .s_axi_arprot(prot_z), .s_axi_arqos(qos_z), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] mdl_mem [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];
  int          rd_n;
  logic [1:0]      cap_bresp;
  logic [ID_W-1:0] cap_bid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---- reference model: closed-form beat addresses from the burst rules ----
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                            input int burst, input int i);
    logic [31:0] bytes, total, bnd;
    bytes = 32'(1) << size;
    total = bytes * 32'(len + 1);
    case (burst)
      1: return (i == 0) ? a : (a / bytes) * bytes + 32'(i) * bytes;
      2: begin
        bnd = (a / total) * total;
        return bnd + ((a - bnd + 32'(i) * bytes) % total);
      end
      default: return a;
    endcase
  endfunction

  function automatic bit is_illegal(input int len, input int size, input int burst);
    return burst == 3 || size > 2 || (burst == 2 && !(len inside {1, 3, 7, 15}));
  endfunction

  function automatic bit in_mem(input logic [31:0] a);
    return (a - BASE) < 32'(4 * DEPTH);
  endfunction

  function automatic logic [1:0] mdl_write(input logic [31:0] addr, input int len, input int size,
                                           input int burst, input int last_at);
    bit dec = 0;
    bit ill = is_illegal(len, size, burst);
    logic [31:0] a;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      if (!in_mem(a)) dec = 1;
      else if (!ill)
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) mdl_mem[(a - BASE) / 4][8*b +: 8] = wd[i][8*b +: 8];
    end
    if (dec) return 2'b11;
    if (ill || last_at != len) return 2'b10;
    return 2'b00;
  endfunction

  // ---- bus driving ----
  task automatic wait_ready(input int ch, output bit ok);
    int t = 0;
    bit hs = 0;
    while (!hs && t < 200) begin
      @(negedge clk);
      case (ch)
        0: hs = awready;
        1: hs = wready;
        2: hs = bvalid;
        default: hs = arready;
      endcase
      if (hs && ch == 2) begin cap_bresp = bresp; cap_bid = bid; end
      @(posedge clk); #1;
      t++;
    end
    ok = hs;
    if (!hs) check("handshake_timeout", 32'(hs), 1);
  endtask

  task automatic wr(input logic [31:0] addr, input int len, input int size, input int burst,
                    input int last_at);
    bit ok;
    logic [ID_W-1:0] id;
    logic [1:0] exp;
    id = ID_W'($urandom);
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1;
    wait_ready(0, ok);
    awvalid = 0;
    if (!ok) return;
    check("wready_latency", 32'(wready), 1);
    for (int i = 0; i <= len; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin wvalid = 0; tick(); end
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_at); wvalid = 1;
      wait_ready(1, ok);
      if (!ok) break;
    end
    wvalid = 0; wlast = 0;
    check("bvalid_latency", 32'(bvalid), 1);
    repeat ($urandom_range(0, 2)) tick();
    bready = 1;
    wait_ready(2, ok);
    bready = 0;
    exp = mdl_write(addr, len, size, burst, last_at);
    if (ok) begin
      check("bresp", 32'(cap_bresp), 32'(exp));
      check("bid", 32'(cap_bid), 32'(id));
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input int size, input int burst,
                         input int stop_after, input bit rnd_rdy);
    bit ok, stalled;
    int t, first, last, want;
    logic [31:0] held;
    logic [ID_W-1:0] id;
    id = ID_W'($urandom);
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1;
    wait_ready(3, ok);
    arvalid = 0;
    rd_n = 0;
    if (!ok) return;
    check("rvalid_latency", 32'(rvalid), 1);
    t = 0; first = -1; last = 0; stalled = 0; held = '0;
    want = (len + 1 < stop_after) ? len + 1 : stop_after;
    while (rd_n < want && t < 2000) begin
      rready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (stalled && rvalid) check("r_stable", rdata, held);
      stalled = rvalid && !rready;
      held = rdata;
      if (rvalid && rready) begin
        if (first < 0) first = t;
        last = t;
        rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp; rd_last[rd_n] = rlast;
        check("rid", 32'(rid), 32'(id));
        rd_n++;
      end
      @(posedge clk); #1;
      t++;
    end
    rready = 0;
    if (rd_n < want) check("r_beat_timeout", 32'(rd_n), 32'(want));
    else if (!rnd_rdy && want == len + 1) check("r_back_to_back", 32'(last - first), 32'(len));
  endtask

  task automatic rd(input logic [31:0] addr, input int len, input int size, input int burst,
                    input bit rnd_rdy);
    logic [31:0] a, exp_d;
    logic [1:0] exp_r;
    do_read(addr, len, size, burst, len + 1, rnd_rdy);
    for (int i = 0; i < rd_n; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      if (!in_mem(a))                          begin exp_d = '0; exp_r = 2'b11; end
      else if (is_illegal(len, size, burst))   begin exp_d = '0; exp_r = 2'b10; end
      else                                     begin exp_d = mdl_mem[(a - BASE) / 4]; exp_r = 2'b00; end
      check("rdata", rd_data[i], exp_d);
      check("rresp", 32'(rd_resp[i]), 32'(exp_r));
      check("rlast", 32'(rd_last[i]), 32'(i == len));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int size, burst, len, last_at;
    logic [31:0] addr;
    awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    wdata = '0; wstrb = '0;
    rst = 1;
    repeat (3) tick();
    check("rst_awready", 32'(awready), 0);
    check("rst_wready",  32'(wready), 0);
    check("rst_bvalid",  32'(bvalid), 0);
    check("rst_arready", 32'(arready), 0);
    check("rst_rvalid",  32'(rvalid), 0);
    check("rst_rdata",   rdata, 0);
    check("rst_rlast",   32'(rlast), 0);
    check("rst_rresp",   32'(rresp), 0);
    check("rst_bresp",   32'(bresp), 0);
    check("rst_bid",     32'(bid), 0);
    check("rst_rid",     32'(rid), 0);
    rst = 0;
    tick();
    check("idle_awready", 32'(awready), 1);
    check("idle_arready", 32'(arready), 1);

    // Give every word a known value.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      wr(32'(k * 1024), 255, 2, 1, 255);
    end

    // Single write / single read.
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    wr(32'h10, 0, 2, 1, 0);
    rd(32'h10, 0, 2, 1, 0);
    check("t1_rdata", rd_data[0], 32'hDEADBEEF);

    // INCR len=3 with rready held high.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    wr(32'h20, 3, 2, 1, 3);
    rd(32'h20, 3, 2, 1, 0);
    check("t2_beat3", rd_data[3], 32'h4);

    // WRAP len=3 from 0x38, then an illegal WRAP len=2.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    wr(32'h38, 3, 2, 2, 3);
    rd(32'h30, 3, 2, 1, 1);
    check("t3_wrap_0x30", rd_data[0], 32'hA2);
    rd(32'h38, 3, 2, 2, 1);
    for (int i = 0; i < 3; i++) begin wd[i] = 32'h5555_0000 + 32'(i); ws[i] = 4'hF; end
    wr(32'h30, 2, 2, 2, 2);
    rd(32'h30, 3, 2, 1, 1);

    // Narrow byte write and FIXED read.
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    wr(32'h40, 0, 2, 1, 0);
    wd[0] = 32'h0000AB00; ws[0] = 4'h2;
    wr(32'h41, 0, 0, 1, 0);
    rd(32'h40, 0, 2, 1, 0);
    check("t4_narrow", rd_data[0], 32'hFFFFABFF);
    rd(32'h40, 3, 2, 0, 1);

    // Out-of-range, straddling the top, illegal size/burst, wlast early.
    wd[0] = 32'h12345678; ws[0] = 4'hF;
    wr(32'(4 * DEPTH), 0, 2, 1, 0);
    rd(32'(4 * DEPTH), 0, 2, 1, 0);
    rd(32'h0, 0, 2, 1, 0);
    rd(32'hFFFF_FFFC, 0, 2, 1, 0);
    for (int i = 0; i < 2; i++) begin wd[i] = 32'hC0DE_0000 + 32'(i); ws[i] = 4'hF; end
    wr(32'(4 * DEPTH - 4), 1, 2, 1, 0);
    rd(32'(4 * DEPTH - 4), 1, 2, 1, 1);
    for (int i = 0; i < 3; i++) begin wd[i] = 32'hBEE0 + 32'(i); ws[i] = 4'hF; end
    wr(32'h50, 2, 2, 1, 1);
    rd(32'h50, 2, 2, 1, 1);
    wr(32'h60, 0, 3, 1, 0);
    rd(32'h60, 1, 3, 1, 1);
    rd(32'h60, 1, 2, 3, 1);

    // Randomized legal bursts, some crossing the top of memory.
    for (int n = 0; n < 30; n++) begin
      size  = $urandom_range(0, 2);
      burst = $urandom_range(0, 2);
      len   = (burst == 2) ? (2 << $urandom_range(0, 3)) - 1 : $urandom_range(0, 15);
      addr  = 32'($urandom_range(0, 4 * DEPTH + 63)) & ~(32'(1 << size) - 32'd1);
      last_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 16) : len;
      for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      wr(addr, len, size, burst, last_at);
      rd(addr, len, size, burst, 1);
    end

    // Reset in the middle of an 8-beat read.
    do_read(32'h20, 7, 2, 1, 2, 1);
    #2 rst = 1;
    #1;
    check("midrst_rvalid",  32'(rvalid), 0);
    check("midrst_bvalid",  32'(bvalid), 0);
    check("midrst_arready", 32'(arready), 0);
    check("midrst_awready", 32'(awready), 0);
    check("midrst_rlast",   32'(rlast), 0);
    tick();
    rst = 0;
    tick();
    check("post_rst_awready", 32'(awready), 1);
    check("post_rst_arready", 32'(arready), 1);
    rd(32'h10, 0, 2, 1, 1);
    rd(32'h20, 3, 2, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
